// File: rtl/ora_checker.sv
// ora_checker: receive-side output response analyzer for a NoC sink node.
// Decodes src/dst/id from each accepted packet, checks destination and
// per-source sequence continuity, keeps saturating statistics, and drives
// programmable backpressure (always ready, periodic, or LFSR pseudo-random).
// Optional simulation-only logging is compiled in with ORA_CHECKER_LOG_EN.
module ora_checker #(
   parameter int          WIDTH        = 32,
   parameter int          N            = 16,
   parameter int          N_ADDR_WIDTH = $clog2(N),
   parameter int          NODE         = 15,
   parameter int          ID_WIDTH     = 8,
   parameter int          CNT_WIDTH    = 32,
   parameter int          BP_MODE      = 0,
   parameter int          BP_PERIOD    = 4,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        data_in,
   input  logic                    valid_in,
   output logic                    ready_out,
   input  logic                    err_clear,
   input  logic [N_ADDR_WIDTH-1:0] query_src,
   output logic [CNT_WIDTH-1:0]    query_count,
   output logic [CNT_WIDTH-1:0]    rx_count,
   output logic [CNT_WIDTH-1:0]    err_dst_count,
   output logic [CNT_WIDTH-1:0]    err_seq_count,
   output logic                    err_flag,
   output logic [N_ADDR_WIDTH-1:0] last_src,
   output logic [ID_WIDTH-1:0]     last_id
);

   localparam int PAY_W = WIDTH - 2*N_ADDR_WIDTH - ID_WIDTH;
   localparam int PER_W = (BP_PERIOD > 1) ? $clog2(BP_PERIOD) : 1;
   localparam logic [PER_W-1:0]     PER_LAST = PER_W'(BP_PERIOD - 1);
   localparam logic [PER_W-1:0]     PER_ONE  = PER_W'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [ID_WIDTH-1:0]  ID_ONE   = ID_WIDTH'(1);
   localparam logic [N_ADDR_WIDTH-1:0] MY_NODE = N_ADDR_WIDTH'(NODE);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   logic [N_ADDR_WIDTH-1:0] pkt_src, pkt_dst;
   logic [ID_WIDTH-1:0]     pkt_id;
   logic                    xfer, dst_err, seq_err;

   logic                    ready_q, ready_d;
   logic [PER_W-1:0]        per_q, per_d;
   logic [15:0]             lfsr_q, lfsr_d;
   logic [CNT_WIDTH-1:0]    rx_q, rx_d, err_dst_q, err_dst_d, err_seq_q, err_seq_d;
   logic [CNT_WIDTH-1:0]    query_q, query_d;
   logic                    err_flag_q, err_flag_d;
   logic [N_ADDR_WIDTH-1:0] last_src_q, last_src_d;
   logic [ID_WIDTH-1:0]     last_id_q, last_id_d;
   logic [N-1:0]            seen_q, seen_d;
   logic [ID_WIDTH-1:0]     exp_q [N];
   logic [ID_WIDTH-1:0]     exp_d [N];
   logic [CNT_WIDTH-1:0]    src_cnt_q [N];
   logic [CNT_WIDTH-1:0]    src_cnt_d [N];

   assign pkt_src = data_in[WIDTH-1 -: N_ADDR_WIDTH];
   assign pkt_dst = data_in[WIDTH-1-N_ADDR_WIDTH -: N_ADDR_WIDTH];
   assign pkt_id  = data_in[WIDTH-1-2*N_ADDR_WIDTH -: ID_WIDTH];

   wire unused_payload = ^data_in[PAY_W-1:0];

   assign xfer    = valid_in & ready_q;
   assign dst_err = xfer & (pkt_dst != MY_NODE);
   assign seq_err = xfer & seen_q[pkt_src] & (pkt_id != exp_q[pkt_src]);

   // Backpressure generator: period counter and LFSR always run; mode picks the source.
   always_comb begin
      per_d   = (per_q == PER_LAST) ? '0 : per_q + PER_ONE;
      lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      ready_d = 1'b1;
      case (BP_MODE)
         1:       ready_d = (per_q != PER_LAST);
         2:       ready_d = lfsr_q[0] | lfsr_q[1];
         default: ready_d = 1'b1;
      endcase
   end

   // Checker datapath: a clear takes effect first so a same-cycle error still lands.
   always_comb begin
      rx_d       = rx_q;
      last_src_d = last_src_q;
      last_id_d  = last_id_q;
      seen_d     = seen_q;
      exp_d      = exp_q;
      src_cnt_d  = src_cnt_q;
      err_dst_d  = err_clear ? '0 : err_dst_q;
      err_seq_d  = err_clear ? '0 : err_seq_q;
      err_flag_d = err_flag_q & ~err_clear;
      query_d    = src_cnt_q[query_src];
      if (xfer) begin
         rx_d               = sat_inc(rx_q);
         src_cnt_d[pkt_src] = sat_inc(src_cnt_q[pkt_src]);
         last_src_d         = pkt_src;
         last_id_d          = pkt_id;
         seen_d[pkt_src]    = 1'b1;
         exp_d[pkt_src]     = pkt_id + ID_ONE;
         if (dst_err) err_dst_d = sat_inc(err_dst_d);
         if (seq_err) err_seq_d = sat_inc(err_seq_d);
         if (dst_err || seq_err) err_flag_d = 1'b1;
      end
   end

   // State registers with synchronous reset; a transfer coincident with rst is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q    <= 1'b0;
         per_q      <= '0;
         lfsr_q     <= LFSR_SEED;
         rx_q       <= '0;
         err_dst_q  <= '0;
         err_seq_q  <= '0;
         err_flag_q <= 1'b0;
         query_q    <= '0;
         last_src_q <= '0;
         last_id_q  <= '0;
         seen_q     <= '0;
         for (int i = 0; i < N; i++) begin
            exp_q[i]     <= '0;
            src_cnt_q[i] <= '0;
         end
      end else begin
         ready_q    <= ready_d;
         per_q      <= per_d;
         lfsr_q     <= lfsr_d;
         rx_q       <= rx_d;
         err_dst_q  <= err_dst_d;
         err_seq_q  <= err_seq_d;
         err_flag_q <= err_flag_d;
         query_q    <= query_d;
         last_src_q <= last_src_d;
         last_id_q  <= last_id_d;
         seen_q     <= seen_d;
         exp_q      <= exp_d;
         src_cnt_q  <= src_cnt_d;
      end
   end

   assign ready_out     = ready_q;
   assign query_count   = query_q;
   assign rx_count      = rx_q;
   assign err_dst_count = err_dst_q;
   assign err_seq_count = err_seq_q;
   assign err_flag      = err_flag_q;
   assign last_src      = last_src_q;
   assign last_id       = last_id_q;

`ifdef ORA_CHECKER_LOG_EN
   // Simulation-only transfer and error log.
   always @(posedge clk) begin
      if (!rst && xfer) begin
         $display("RECV; time=%0d; from=%0d; to=%0d; id=%0d; data=%0d;",
                  $time, pkt_src, pkt_dst, pkt_id, data_in[PAY_W-1:0]);
         if (dst_err)
            $display("ERR_DST; time=%0d; from=%0d; to=%0d;", $time, pkt_src, pkt_dst);
         if (seq_err)
            $display("ERR_SEQ; time=%0d; from=%0d; exp=%0d; got=%0d;",
                     $time, pkt_src, exp_q[pkt_src], pkt_id);
      end
   end
`endif

endmodule

// File: tb/tb_ora_checker.sv
// Testbench for ora_checker: four instances cover always-ready, periodic and
// LFSR backpressure, plus a 4-bit counter build for saturation and mid-burst reset.
module tb_ora_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // u0: BP_MODE=0 defaults
   logic rst0, valid0, errclr0, ready0, flag0;
   logic [31:0] data0, qcnt0, rx0, edst0, eseq0;
   logic [3:0]  qsrc0, lsrc0;
   logic [7:0]  lid0;
   // u1: BP_MODE=1, period 4
   logic rst1, valid1, errclr1, ready1, flag1;
   logic [31:0] data1, qcnt1, rx1, edst1, eseq1;
   logic [3:0]  qsrc1, lsrc1;
   logic [7:0]  lid1;
   // u2: BP_MODE=2, default seed
   logic rst2, valid2, errclr2, ready2, flag2;
   logic [31:0] data2, qcnt2, rx2, edst2, eseq2;
   logic [3:0]  qsrc2, lsrc2;
   logic [7:0]  lid2;
   // u3: BP_MODE=0, CNT_WIDTH=4
   logic rst3, valid3, errclr3, ready3, flag3;
   logic [31:0] data3;
   logic [3:0]  qcnt3, rx3, edst3, eseq3;
   logic [3:0]  qsrc3, lsrc3;
   logic [7:0]  lid3;

   ora_checker #(.BP_MODE(0)) u0 (
      .clk(clk), .rst(rst0), .data_in(data0), .valid_in(valid0), .ready_out(ready0),
      .err_clear(errclr0), .query_src(qsrc0), .query_count(qcnt0), .rx_count(rx0),
      .err_dst_count(edst0), .err_seq_count(eseq0), .err_flag(flag0),
      .last_src(lsrc0), .last_id(lid0));

   ora_checker #(.BP_MODE(1), .BP_PERIOD(4)) u1 (
      .clk(clk), .rst(rst1), .data_in(data1), .valid_in(valid1), .ready_out(ready1),
      .err_clear(errclr1), .query_src(qsrc1), .query_count(qcnt1), .rx_count(rx1),
      .err_dst_count(edst1), .err_seq_count(eseq1), .err_flag(flag1),
      .last_src(lsrc1), .last_id(lid1));

   ora_checker #(.BP_MODE(2)) u2 (
      .clk(clk), .rst(rst2), .data_in(data2), .valid_in(valid2), .ready_out(ready2),
      .err_clear(errclr2), .query_src(qsrc2), .query_count(qcnt2), .rx_count(rx2),
      .err_dst_count(edst2), .err_seq_count(eseq2), .err_flag(flag2),
      .last_src(lsrc2), .last_id(lid2));

   ora_checker #(.BP_MODE(0), .CNT_WIDTH(4)) u3 (
      .clk(clk), .rst(rst3), .data_in(data3), .valid_in(valid3), .ready_out(ready3),
      .err_clear(errclr3), .query_src(qsrc3), .query_count(qcnt3), .rx_count(rx3),
      .err_dst_count(edst3), .err_seq_count(eseq3), .err_flag(flag3),
      .last_src(lsrc3), .last_id(lid3));

   function automatic logic [31:0] pkt(input int s, input int d, input int i);
      return {s[3:0], d[3:0], i[7:0], 16'hA5A5};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got=%0d expected=%0d", tag, actual, expected);
      end
   endtask

   initial begin
      int nid;
      int xfers;
      bit willXfer;
      bit modelReady;
      int lfsr;
      int fb;

      rst0 = 1; valid0 = 0; errclr0 = 0; data0 = '0; qsrc0 = 4'd3;
      rst1 = 1; valid1 = 0; errclr1 = 0; data1 = '0; qsrc1 = 4'd1;
      rst2 = 1; valid2 = 0; errclr2 = 0; data2 = '0; qsrc2 = 4'd4;
      rst3 = 1; valid3 = 0; errclr3 = 0; data3 = '0; qsrc3 = 4'd6;
      step();
      step();

      // Mode 0: reset state
      checkOutput("rst_ready", ready0, 0);
      checkOutput("rst_rx", rx0, 0);
      checkOutput("rst_flag", flag0, 0);
      checkOutput("rst_query", qcnt0, 0);
      checkOutput("rst_last_src", lsrc0, 0);
      rst0 = 0;
      step();
      checkOutput("m0_ready_after_rst", ready0, 1);

      // Mode 0: ten back-to-back packets from src 3
      valid0 = 1;
      for (int i = 0; i < 10; i++) begin
         data0 = pkt(3, 15, i);
         step();
      end
      checkOutput("m0_rx10", rx0, 10);
      checkOutput("m0_query_latency", qcnt0, 9);
      checkOutput("m0_last_id", lid0, 9);
      checkOutput("m0_last_src", lsrc0, 3);
      valid0 = 0;
      step();
      checkOutput("m0_query10", qcnt0, 10);
      checkOutput("m0_flag0", flag0, 0);
      checkOutput("m0_ready_idle", ready0, 1);

      // ID wrap 254,255,0,1 then a jump to 5 and resync at 6
      valid0 = 1;
      for (int i = 0; i < 4; i++) begin
         data0 = pkt(5, 15, (254 + i) % 256);
         step();
      end
      checkOutput("wrap_seq0", eseq0, 0);
      data0 = pkt(5, 15, 5);
      step();
      checkOutput("jump_seq1", eseq0, 1);
      checkOutput("jump_flag", flag0, 1);
      data0 = pkt(5, 15, 6);
      step();
      checkOutput("resync_seq1", eseq0, 1);
      checkOutput("dst_none", edst0, 0);

      // Clear errors, then a wrong-destination first packet
      valid0 = 0; errclr0 = 1;
      step();
      errclr0 = 0;
      checkOutput("clr_seq", eseq0, 0);
      checkOutput("clr_flag", flag0, 0);
      valid0 = 1; data0 = pkt(2, 7, 0);
      step();
      checkOutput("dst_err1", edst0, 1);
      checkOutput("dst_seq0", eseq0, 0);
      checkOutput("dst_flag", flag0, 1);
      data0 = pkt(2, 9, 1); errclr0 = 1;
      step();
      errclr0 = 0; valid0 = 0;
      checkOutput("clr_vs_err_dst", edst0, 1);
      checkOutput("clr_vs_err_flag", flag0, 1);
      checkOutput("clr_vs_err_seq", eseq0, 0);
      qsrc0 = 4'd5;
      step();
      checkOutput("query_src5", qcnt0, 6);
      checkOutput("rx_total", rx0, 18);

      // Mode 1: periodic backpressure, valid held for 40 cycles
      rst1 = 0;
      valid1 = 1;
      nid = 0;
      for (int k = 1; k <= 40; k++) begin
         data1 = pkt(1, 15, nid);
         willXfer = ready1;
         step();
         checkOutput("m1_ready", ready1, ((k % 4) != 0) ? 1 : 0);
         if (willXfer) nid++;
      end
      valid1 = 0;
      checkOutput("m1_rx30", rx1, 30);
      checkOutput("m1_last_id", lid1, 29);
      checkOutput("m1_seq0", eseq1, 0);
      step();
      checkOutput("m1_query", qcnt1, 30);

      // Mode 2: LFSR backpressure against a reference model
      rst2 = 0;
      valid2 = 1;
      nid = 0;
      xfers = 0;
      modelReady = 0;
      lfsr = 32'hACE1;
      for (int k = 0; k < 1000; k++) begin
         data2 = pkt(4, 15, nid);
         willXfer = modelReady;
         step();
         modelReady = ((lfsr & 3) != 0);
         fb = (lfsr ^ (lfsr >> 2) ^ (lfsr >> 3) ^ (lfsr >> 5)) & 1;
         lfsr = (lfsr >> 1) | (fb << 15);
         checkOutput("m2_ready", ready2, modelReady);
         if (willXfer) begin
            xfers++;
            nid++;
         end
      end
      valid2 = 0;
      checkOutput("m2_rx", rx2, xfers);
      checkOutput("m2_seq0", eseq2, 0);

      // 4-bit counters: saturation
      rst3 = 0;
      step();
      valid3 = 1;
      for (int i = 0; i < 20; i++) begin
         data3 = pkt(6, 15, i);
         step();
      end
      checkOutput("sat_rx", rx3, 15);
      checkOutput("sat_last_id", lid3, 19);
      valid3 = 0;
      step();
      checkOutput("sat_query", qcnt3, 15);

      // Mid-burst reset with valid high; coincident packet is discarded
      valid3 = 1;
      for (int i = 20; i < 22; i++) begin
         data3 = pkt(6, 15, i);
         step();
      end
      data3 = pkt(6, 15, 50);
      rst3 = 1;
      step();
      checkOutput("mrst_ready", ready3, 0);
      checkOutput("mrst_rx", rx3, 0);
      checkOutput("mrst_query", qcnt3, 0);
      checkOutput("mrst_last_id", lid3, 0);
      checkOutput("mrst_last_src", lsrc3, 0);
      checkOutput("mrst_flag", flag3, 0);
      rst3 = 0;
      step();
      checkOutput("mrst_no_xfer", rx3, 0);
      step();
      valid3 = 0;
      checkOutput("mrst_rx1", rx3, 1);
      checkOutput("mrst_seq0", eseq3, 0);
      checkOutput("mrst_flag0", flag3, 0);
      checkOutput("mrst_id50", lid3, 50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
